// File: rtl/pipeline_test_controller_if.sv
// Bus bundle between the run-and-check harness and whoever drives it (bench or SoC glue).
// Strobes: st_valid/pc_valid qualify their payload in the same cycle; there is no ready, the harness never back-pressures.
interface pipeline_test_controller_if #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int NUM_CHECKS = 4,
    parameter int CNT_W      = 16
);
    localparam int IDX_W = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;

    logic              start;
    logic              chk_wr_en;
    logic [IDX_W-1:0]  chk_idx;
    logic [ADDR_W-1:0] chk_addr;
    logic [DATA_W-1:0] chk_data;
    logic              st_valid;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic              pc_valid;
    logic [ADDR_W-1:0] pc_in;
    logic              core_reset;
    logic              busy;
    logic              done;
    logic              pass;
    logic              timeout;
    logic [IDX_W:0]    fail_count;
    logic [IDX_W-1:0]  first_fail_idx;
    logic [CNT_W-1:0]  cycle_count;
    logic [2:0]        dbg_state;

    modport master (
        output start, chk_wr_en, chk_idx, chk_addr, chk_data,
        output st_valid, st_addr, st_data, pc_valid, pc_in,
        input  core_reset, busy, done, pass, timeout,
        input  fail_count, first_fail_idx, cycle_count, dbg_state
    );

    modport slave (
        input  start, chk_wr_en, chk_idx, chk_addr, chk_data,
        input  st_valid, st_addr, st_data, pc_valid, pc_in,
        output core_reset, busy, done, pass, timeout,
        output fail_count, first_fail_idx, cycle_count, dbg_state
    );
endinterface

// File: rtl/pipeline_test_controller.sv
// Run-and-check harness for riscv_pipeline: holds the core in reset, runs it until a PC
// halt loop or timeout while snooping stores, then scores the captured stores against a table.
module pipeline_test_controller #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int NUM_CHECKS     = 4,
    parameter int RESET_CYCLES   = 2,
    parameter int HALT_REPEAT    = 3,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CNT_W          = 16
) (
    input logic                        clk,
    input logic                        reset,
    pipeline_test_controller_if.slave  bus
);
    localparam int IDX_W  = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;
    localparam int HOLD_W = $clog2(RESET_CYCLES) + 1;
    localparam int REP_W  = $clog2(HALT_REPEAT) + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HOLD  = 3'd1,
        S_RUN   = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [REP_W-1:0]    rep_q, rep_d;
    logic [ADDR_W-1:0]   prev_pc_q, prev_pc_d;
    logic                prev_valid_q, prev_valid_d;
    logic [CNT_W-1:0]    cyc_q, cyc_d;
    logic                timeout_q, timeout_d;
    logic [IDX_W:0]      fail_q, fail_d;
    logic [IDX_W-1:0]    ffi_q, ffi_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [NUM_CHECKS-1:0] ent_valid_q, ent_valid_d;
    logic [NUM_CHECKS-1:0] ent_hit_q, ent_hit_d;
    logic [ADDR_W-1:0]   ent_addr_q [NUM_CHECKS];
    logic [ADDR_W-1:0]   ent_addr_d [NUM_CHECKS];
    logic [DATA_W-1:0]   ent_exp_q  [NUM_CHECKS];
    logic [DATA_W-1:0]   ent_exp_d  [NUM_CHECKS];
    logic [DATA_W-1:0]   ent_cap_q  [NUM_CHECKS];
    logic [DATA_W-1:0]   ent_cap_d  [NUM_CHECKS];
    logic                launch;
    logic                halt;
    logic                tmo;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            hold_q       <= '0;
            rep_q        <= '0;
            prev_pc_q    <= '0;
            prev_valid_q <= 1'b0;
            cyc_q        <= '0;
            timeout_q    <= 1'b0;
            fail_q       <= '0;
            ffi_q        <= '1;
            idx_q        <= '0;
            ent_valid_q  <= '0;
            ent_hit_q    <= '0;
            ent_addr_q   <= '{default: '0};
            ent_exp_q    <= '{default: '0};
            ent_cap_q    <= '{default: '0};
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            rep_q        <= rep_d;
            prev_pc_q    <= prev_pc_d;
            prev_valid_q <= prev_valid_d;
            cyc_q        <= cyc_d;
            timeout_q    <= timeout_d;
            fail_q       <= fail_d;
            ffi_q        <= ffi_d;
            idx_q        <= idx_d;
            ent_valid_q  <= ent_valid_d;
            ent_hit_q    <= ent_hit_d;
            ent_addr_q   <= ent_addr_d;
            ent_exp_q    <= ent_exp_d;
            ent_cap_q    <= ent_cap_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        rep_d        = rep_q;
        prev_pc_d    = prev_pc_q;
        prev_valid_d = prev_valid_q;
        cyc_d        = cyc_q;
        timeout_d    = timeout_q;
        fail_d       = fail_q;
        ffi_d        = ffi_q;
        idx_d        = idx_q;
        ent_valid_d  = ent_valid_q;
        ent_hit_d    = ent_hit_q;
        ent_addr_d   = ent_addr_q;
        ent_exp_d    = ent_exp_q;
        ent_cap_d    = ent_cap_q;
        launch       = 1'b0;
        halt         = 1'b0;
        tmo          = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.chk_wr_en && (32'(bus.chk_idx) < NUM_CHECKS)) begin
                    ent_valid_d[bus.chk_idx] = 1'b1;
                    ent_addr_d[bus.chk_idx]  = bus.chk_addr;
                    ent_exp_d[bus.chk_idx]   = bus.chk_data;
                end
                launch = bus.start;
            end
            S_HOLD: begin
                if (hold_q == HOLD_W'(RESET_CYCLES - 1)) begin
                    state_d      = S_RUN;
                    rep_d        = '0;
                    prev_valid_d = 1'b0;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            S_RUN: begin
                cyc_d = (cyc_q == '1) ? cyc_q : cyc_q + CNT_W'(1);
                if (bus.st_valid) begin
                    for (int i = 0; i < NUM_CHECKS; i++) begin
                        if (ent_valid_q[i] && (ent_addr_q[i] == bus.st_addr)) begin
                            ent_cap_d[i] = bus.st_data;
                            ent_hit_d[i] = 1'b1;
                        end
                    end
                end
                // A repeat is only counted against a PC seen as valid earlier in this run.
                if (bus.pc_valid) begin
                    prev_pc_d    = bus.pc_in;
                    prev_valid_d = 1'b1;
                    rep_d = (prev_valid_q && (bus.pc_in == prev_pc_q)) ? rep_q + REP_W'(1) : '0;
                end else begin
                    rep_d = '0;
                end
                halt = (rep_d == REP_W'(HALT_REPEAT - 1));
                tmo  = (cyc_q == CNT_W'(TIMEOUT_CYCLES - 1));
                if (halt) begin
                    state_d = S_CHECK;
                end else if (tmo) begin
                    state_d   = S_CHECK;
                    timeout_d = 1'b1;
                end
            end
            S_CHECK: begin
                if (ent_valid_q[idx_q] &&
                    (!ent_hit_q[idx_q] || (ent_cap_q[idx_q] != ent_exp_q[idx_q]))) begin
                    fail_d = fail_q + (IDX_W + 1)'(1);
                    if (fail_q == '0) ffi_d = idx_q;
                end
                if (idx_q == IDX_W'(NUM_CHECKS - 1)) state_d = S_DONE;
                else                                 idx_d   = idx_q + IDX_W'(1);
            end
            S_DONE: begin
                launch = bus.start;
            end
            default: state_d = S_IDLE;
        endcase

        // Relaunch keeps the expected table but discards everything from the previous run.
        if (launch) begin
            state_d   = S_HOLD;
            hold_d    = '0;
            ent_hit_d = '0;
            cyc_d     = '0;
            timeout_d = 1'b0;
            fail_d    = '0;
            ffi_d     = '1;
            idx_d     = '0;
        end
    end

    // Outputs
    always_comb begin
        bus.core_reset     = (state_q != S_RUN);
        bus.busy           = (state_q == S_HOLD) || (state_q == S_RUN) || (state_q == S_CHECK);
        bus.done           = (state_q == S_DONE);
        bus.pass           = (state_q == S_DONE) && (fail_q == '0) && !timeout_q;
        bus.timeout        = timeout_q;
        bus.fail_count     = fail_q;
        bus.first_fail_idx = ffi_q;
        bus.cycle_count    = cyc_q;
        bus.dbg_state      = state_q;
    end
endmodule

// File: tb/tb_pipeline_test_controller.sv
// Directed bench for pipeline_test_controller: each run pushes its expected result record,
// a monitor pops and compares it when done rises.
module tb_pipeline_test_controller;
    localparam int ADDR_W       = 32;
    localparam int DATA_W       = 32;
    localparam int NUM_CHECKS   = 4;
    localparam int IDX_W        = 2;
    localparam int CNT_W        = 16;
    localparam int RESET_CYCLES = 2;
    localparam int HALT_REPEAT  = 3;
    localparam int TIMEOUT      = 20;
    localparam int W            = 23;  // {pass, timeout, fail_count[2:0], first_fail[1:0], cycles[15:0]}

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] e;
    logic done_prev = 1'b0;

    pipeline_test_controller_if #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_CHECKS(NUM_CHECKS), .CNT_W(CNT_W)
    ) bus ();

    pipeline_test_controller #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_CHECKS(NUM_CHECKS),
        .RESET_CYCLES(RESET_CYCLES), .HALT_REPEAT(HALT_REPEAT),
        .TIMEOUT_CYCLES(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] pack(input logic p, input logic t, input logic [2:0] fc,
                                          input logic [1:0] ffi, input logic [15:0] cc);
        return {p, t, fc, ffi, cc};
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        if (bus.done && !done_prev) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("pass",           32'(bus.pass),           32'(e[22]));
                chk("timeout",        32'(bus.timeout),        32'(e[21]));
                chk("fail_count",     32'(bus.fail_count),     32'(e[20:18]));
                chk("first_fail_idx", 32'(bus.first_fail_idx), 32'(e[17:16]));
                chk("cycle_count",    32'(bus.cycle_count),    32'(e[15:0]));
                chk("core_reset_done", 32'(bus.core_reset),    32'd1);
            end
        end
        done_prev = bus.done;
    end

    // Driver tasks (all entered and left at a negedge)
    task automatic idle_inputs();
        bus.start     = 1'b0;
        bus.chk_wr_en = 1'b0;
        bus.chk_idx   = '0;
        bus.chk_addr  = '0;
        bus.chk_data  = '0;
        bus.st_valid  = 1'b0;
        bus.st_addr   = '0;
        bus.st_data   = '0;
        bus.pc_valid  = 1'b0;
        bus.pc_in     = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic prog(input int idx, input logic [31:0] a, input logic [31:0] d);
        bus.chk_wr_en = 1'b1;
        bus.chk_idx   = IDX_W'(idx);
        bus.chk_addr  = a;
        bus.chk_data  = d;
        @(negedge clk);
        bus.chk_wr_en = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < RESET_CYCLES; i++) begin
            chk("core_reset_hold", 32'(bus.core_reset), 32'd1);
            @(negedge clk);
        end
        chk("core_reset_release", 32'(bus.core_reset), 32'd0);
    endtask

    task automatic run_cycle(input logic pv, input logic [31:0] pc, input logic sv,
                             input logic [31:0] sa, input logic [31:0] sd);
        bus.pc_valid = pv;
        bus.pc_in    = pc;
        bus.st_valid = sv;
        bus.st_addr  = sa;
        bus.st_data  = sd;
        @(negedge clk);
    endtask

    task automatic halt_tail();
        for (int i = 0; i < HALT_REPEAT; i++) run_cycle(1'b1, 32'hA0, 1'b0, 32'h0, 32'h0);
        idle_inputs();
    endtask

    task automatic wait_done();
        int n = 0;
        while (!bus.done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("done_latency", 32'(n), 32'(NUM_CHECKS));
    endtask

    // Stimulus
    initial begin
        idle_inputs();
        repeat (3) @(negedge clk);
        reset = 1'b0;

        chk("rst_core_reset", 32'(bus.core_reset),     32'd1);
        chk("rst_busy",       32'(bus.busy),           32'd0);
        chk("rst_done",       32'(bus.done),           32'd0);
        chk("rst_pass",       32'(bus.pass),           32'd0);
        chk("rst_timeout",    32'(bus.timeout),        32'd0);
        chk("rst_fail_count", 32'(bus.fail_count),     32'd0);
        chk("rst_first_fail", 32'(bus.first_fail_idx), 32'd3);
        chk("rst_cycles",     32'(bus.cycle_count),    32'd0);

        // Single pass
        prog(0, 32'h08, 32'h14);
        exp_q.push_back(pack(1'b1, 1'b0, 3'd0, 2'd3, 16'd5));
        do_start();
        run_cycle(1'b1, 32'h00, 1'b1, 32'h08, 32'h14);
        run_cycle(1'b1, 32'h04, 1'b0, 32'h00, 32'h00);
        halt_tail();
        wait_done();

        // Rerun from DONE; a table write during RUN must be ignored
        exp_q.push_back(pack(1'b1, 1'b0, 3'd0, 2'd3, 16'd5));
        do_start();
        run_cycle(1'b1, 32'h00, 1'b1, 32'h08, 32'h14);
        bus.chk_wr_en = 1'b1;
        bus.chk_idx   = 2'd0;
        bus.chk_addr  = 32'h08;
        bus.chk_data  = 32'h99;
        run_cycle(1'b1, 32'h04, 1'b0, 32'h00, 32'h00);
        bus.chk_wr_en = 1'b0;
        halt_tail();
        wait_done();

        // Rerun without the store: hit bits must have been cleared
        exp_q.push_back(pack(1'b0, 1'b0, 3'd1, 2'd0, 16'd5));
        do_start();
        run_cycle(1'b1, 32'h00, 1'b0, 32'h00, 32'h00);
        run_cycle(1'b1, 32'h04, 1'b0, 32'h00, 32'h00);
        halt_tail();
        wait_done();

        // Mismatch plus missing store
        do_reset();
        chk("reset_from_done", 32'(bus.done), 32'd0);
        prog(0, 32'h08, 32'h14);
        prog(2, 32'h10, 32'h1E);
        exp_q.push_back(pack(1'b0, 1'b0, 3'd2, 2'd0, 16'd5));
        do_start();
        run_cycle(1'b1, 32'h00, 1'b1, 32'h08, 32'h15);
        run_cycle(1'b1, 32'h04, 1'b0, 32'h00, 32'h00);
        halt_tail();
        wait_done();

        // Overwrite: last store wins
        do_reset();
        prog(1, 32'h04, 32'h0A);
        exp_q.push_back(pack(1'b1, 1'b0, 3'd0, 2'd3, 16'd5));
        do_start();
        run_cycle(1'b1, 32'h00, 1'b1, 32'h04, 32'h05);
        run_cycle(1'b1, 32'h04, 1'b1, 32'h04, 32'h0A);
        halt_tail();
        wait_done();

        exp_q.push_back(pack(1'b0, 1'b0, 3'd1, 2'd1, 16'd5));
        do_start();
        run_cycle(1'b1, 32'h00, 1'b1, 32'h04, 32'h0A);
        run_cycle(1'b1, 32'h04, 1'b1, 32'h04, 32'h05);
        halt_tail();
        wait_done();

        // Timeout with an incrementing PC
        do_reset();
        exp_q.push_back(pack(1'b0, 1'b1, 3'd0, 2'd3, 16'd20));
        do_start();
        for (int i = 0; i < TIMEOUT; i++) run_cycle(1'b1, 32'(i * 4), 1'b0, 32'h0, 32'h0);
        idle_inputs();
        wait_done();

        // Halt lands on the final RUN cycle: halt wins over timeout
        exp_q.push_back(pack(1'b1, 1'b0, 3'd0, 2'd3, 16'd20));
        do_start();
        for (int i = 0; i < TIMEOUT - HALT_REPEAT; i++) run_cycle(1'b1, 32'(i * 4), 1'b0, 32'h0, 32'h0);
        halt_tail();
        wait_done();

        // Reset mid-RUN aborts and clears the table
        do_reset();
        prog(3, 32'h20, 32'h33);
        do_start();
        for (int i = 0; i < 3; i++) run_cycle(1'b1, 32'(i * 4), 1'b0, 32'h0, 32'h0);
        chk("mid_run_busy", 32'(bus.busy), 32'd1);
        idle_inputs();
        do_reset();
        chk("abort_state",      32'(bus.dbg_state),  32'd0);
        chk("abort_core_reset", 32'(bus.core_reset), 32'd1);
        chk("abort_busy",       32'(bus.busy),       32'd0);
        chk("abort_done",       32'(bus.done),       32'd0);
        chk("abort_cycles",     32'(bus.cycle_count), 32'd0);
        exp_q.push_back(pack(1'b1, 1'b0, 3'd0, 2'd3, 16'd5));
        do_start();
        run_cycle(1'b1, 32'h00, 1'b0, 32'h00, 32'h00);
        run_cycle(1'b1, 32'h04, 1'b0, 32'h00, 32'h00);
        halt_tail();
        wait_done();

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipeline_test_controller.md
Name: pipeline_test_controller

Overview:
- Synthesizable, parametrised run-and-check harness for riscv_pipeline.
- Holds the core in reset, releases it, and snoops the data-memory store bus.
- Ends the run on a halt loop (PC stuck, e.g. jal x0,0) or on timeout.
- Compares final stored values at up to NUM_CHECKS programmed addresses against expected values, then reports pass/fail, fail count and cycle count.

Parameters:
- ADDR_W, 32, store/PC address width.
- DATA_W, 32, store data width.
- NUM_CHECKS, 4, check-table entries (>=1).
- IDX_W, $clog2(NUM_CHECKS) min 1, index width.
- RESET_CYCLES, 2, cycles core_reset is held after start (>=1).
- HALT_REPEAT, 3, consecutive cycles with unchanged valid PC that count as halt (>=2).
- TIMEOUT_CYCLES, 1000, maximum RUN cycles.
- CNT_W, 16, cycle counter width.

Ports:
- clk, in, 1, clock.
- reset, in, 1, synchronous active-high reset.
- start, in, 1, launch run; honoured only in IDLE or DONE.
- chk_wr_en, in, 1, write check entry; honoured only in IDLE.
- chk_idx, in, IDX_W, entry index.
- chk_addr, in, ADDR_W, byte address to check.
- chk_data, in, DATA_W, expected value.
- st_valid, in, 1, core data-memory write strobe.
- st_addr, in, ADDR_W, store address.
- st_data, in, DATA_W, store data.
- pc_valid, in, 1, pc_in meaningful this cycle.
- pc_in, in, ADDR_W, current fetch PC.
- core_reset, out, 1, reset to riscv_pipeline.
- busy, out, 1, state is HOLD, RUN or CHECK.
- done, out, 1, state is DONE.
- pass, out, 1, fail_count==0 and !timeout; valid when done.
- timeout, out, 1, run ended by TIMEOUT_CYCLES.
- fail_count, out, IDX_W+1, number of failing valid entries.
- first_fail_idx, out, IDX_W, lowest failing index; all ones if none.
- cycle_count, out, CNT_W, RUN cycles elapsed, saturating.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high, port name reset. All state updates on posedge clk.
- Reset values:
  - state IDLE; core_reset=1; busy=0; done=0; pass=0; timeout=0.
  - fail_count=0; first_fail_idx=all ones; cycle_count=0.
  - All table valid/hit bits=0. Captured data is don't-care.
- Reset asserted in any state aborts the run the same cycle and clears the table.
- IDLE:
  - core_reset=1.
  - chk_wr_en writes {valid=1, addr, expected} at chk_idx; a later write to the same index overwrites.
  - An out-of-range chk_idx is ignored.
  - start -> HOLD next cycle. Any chk_wr_en in the same cycle is still applied.
- Start in DONE: start -> HOLD, clears hit bits, result outputs and cycle_count; keeps expected table. chk_wr_en is ignored outside IDLE.
- HOLD:
  - core_reset=1 for exactly RESET_CYCLES cycles, then RUN.
  - core_reset is 0 from the first RUN cycle.
- RUN:
  - cycle_count increments every cycle, saturating at all ones.
  - Snoop: if st_valid, every valid entry with addr==st_addr gets captured<=st_data, hit<=1. Duplicate addresses all update; the last store wins.
  - Halt detect:
    - Internal repeat counter: if pc_valid and pc_in==previous valid pc, increment, else clear.
    - When the counter reaches HALT_REPEAT-1 -> CHECK.
    - pc_valid=0 clears the counter.
  - Timeout: when cycle_count reaches TIMEOUT_CYCLES-1 without halt -> CHECK with timeout=1.
  - Halt and timeout in the same cycle: halt wins, timeout=0.
  - A store in the exit cycle is still captured.
- CHECK:
  - core_reset=1 (core frozen).
  - Evaluates one entry per cycle, index 0..NUM_CHECKS-1, so it takes NUM_CHECKS cycles.
  - An entry fails if valid && (!hit || captured!=expected). Invalid entries are skipped.
  - On a fail: fail_count++; first_fail_idx set on the first fail only.
  - After the last entry -> DONE.
- DONE:
  - done=1 and pass are valid from the first DONE cycle.
  - Outputs hold until start or reset; core_reset=1.
- start while busy is ignored.
- Latency: start edge to core_reset=0 is RESET_CYCLES+1 cycles. Halt edge to done is NUM_CHECKS+1 cycles.

Test Plan:
- Single pass: program idx0 {0x08, 0x00000014}; start; drive store (0x08, 0x14) in RUN; hold PC 0xA0 for 3 cycles -> done=1, pass=1, fail_count=0, first_fail_idx=3, timeout=0.
- Mismatch plus missing store: idx0 {0x08, 0x14}, idx2 {0x10, 0x1E}; store (0x08, 0x15) only; halt -> pass=0, fail_count=2, first_fail_idx=0.
- Overwrite: idx1 {0x04, 0x0A}; stores (0x04, 0x05) then (0x04, 0x0A) -> pass=1. Reversed order -> fail_count=1.
- Timeout, with TIMEOUT_CYCLES=20 and PC incrementing each cycle -> timeout=1, pass=0, cycle_count=20. Halt in the final RUN cycle instead -> timeout=0.
- Reset timing: start; check core_reset=1 for RESET_CYCLES cycles after start is sampled. Assert reset mid-RUN -> next cycle IDLE, core_reset=1, table invalid, done=0.
- Rerun from DONE: start again without reprogramming -> expected table retained, hit cleared, same result reproduced. chk_wr_en during RUN has no effect.
